// File: rtl/serializer_pkg.sv
// Shared types and helpers for the bit serializer: FSM state encoding and the
// effective-frame-length rule applied when a word is accepted.
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Zero or oversize requests mean "send the whole word".
  function automatic int unsigned len_eff(input int unsigned len, input int unsigned width);
    return ((len == 0) || (len > width)) ? width : len;
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial stimulus stage: accepts words over valid/ready and shifts
// them out MSB-first on x, with a one-entry pending buffer for gap-free frames.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] in_len,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy
);

  state_t             r_state;
  logic [WIDTH-1:0]   r_shreg;
  logic [LEN_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_pend_data;
  logic [LEN_W-1:0]   r_pend_len;
  logic               r_pend_full;
  logic               r_ready;
  logic               r_x;
  logic               r_x_valid;
  logic               r_frame_start;
  logic               r_frame_last;
  logic               r_busy;

  logic               w_accept;
  logic               w_is_last;
  logic               w_start;
  logic               w_more_bits;
  logic               w_shift_next;
  logic               w_pend_next;
  logic [LEN_W-1:0]   w_len_in;

  // r_cnt counts the bits still to follow the one currently on x.
  always_comb begin
    w_accept     = in_valid && r_ready;
    w_is_last    = (r_state == SHIFT) && (r_cnt == '0);
    w_more_bits  = (r_state == SHIFT) && (r_cnt != '0);
    w_start      = r_pend_full && ((r_state == IDLE) || w_is_last);
    w_shift_next = w_start || w_more_bits;
    w_pend_next  = w_accept || (r_pend_full && !w_start);
    w_len_in     = LEN_W'(len_eff(32'(in_len), WIDTH));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_pend_full   <= 1'b0;
      r_ready       <= 1'b0;
      r_x           <= 1'b0;
      r_x_valid     <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_last  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_pend_full <= w_pend_next;
      r_ready     <= !w_pend_next;
      r_busy      <= w_shift_next || w_pend_next;

      if (w_start) begin
        r_state       <= SHIFT;
        r_cnt         <= r_pend_len - LEN_W'(1);
        r_x           <= r_pend_data[WIDTH-1];
        r_x_valid     <= 1'b1;
        r_frame_start <= 1'b1;
        r_frame_last  <= (r_pend_len == LEN_W'(1));
      end else if (w_more_bits) begin
        r_cnt         <= r_cnt - LEN_W'(1);
        r_x           <= r_shreg[WIDTH-1];
        r_x_valid     <= 1'b1;
        r_frame_start <= 1'b0;
        r_frame_last  <= (r_cnt == LEN_W'(1));
      end else begin
        r_state       <= IDLE;
        r_x           <= 1'b0;
        r_x_valid     <= 1'b0;
        r_frame_start <= 1'b0;
        r_frame_last  <= 1'b0;
      end
    end
  end

  // NOTE: the data words carry no reset; they are only read after a
  // controlling flag (pend_full / SHIFT) has been set, which is reset above.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pend_data <= in_data;
      r_pend_len  <= w_len_in;
    end
    if (w_start) begin
      r_shreg <= r_pend_data << 1;
    end else if (w_more_bits) begin
      r_shreg <= r_shreg << 1;
    end
  end

  assign in_ready    = r_ready;
  assign x           = r_x;
  assign x_valid     = r_x_valid;
  assign frame_start = r_frame_start;
  assign frame_last  = r_frame_last;
  assign busy        = r_busy;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: a frame-schedule model predicts every output cycle
// by cycle; directed frames pin the model with literal bit patterns.
module tb_bit_serializer;

  localparam int W  = 64;
  localparam int LW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic [LW-1:0] in_len = '0;
  logic          in_ready, x, x_valid, frame_start, frame_last, busy;

  bit_serializer #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_len(in_len), .x(x), .x_valid(x_valid),
    .frame_start(frame_start), .frame_last(frame_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] data; logic [LW-1:0] len; int gap; } word_t;
  typedef struct { bit x; bit fs; bit fl; } slot_t;

  word_t stim[$];
  slot_t sched[int];
  int    cyc = -1;
  int    n_chk = 0, n_err = 0;

  int    last_end = -10, pend_lo = 0, pend_hi = -1, last_acc = -1;
  bit    prev_rst = 1'b1;

  bit    cap[$];
  int    first_xv = -1, last_xv = -1, fs_cnt = 0, fl_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int model_len(input logic [LW-1:0] l);
    int v;
    v = int'(l);
    return ((v == 0) || (v > W)) ? W : v;
  endfunction

  always @(posedge clk) cyc++;

  // Producer: presents the head of stim (after its idle gap) until the model accepts it.
  always @(posedge clk) begin
    #1;
    if (stim.size() > 0 && stim[0].gap > 0) begin
      in_valid = 1'b0;
      stim[0].gap--;
      in_data = {$urandom, $urandom};
      in_len  = LW'($urandom);
    end else if (stim.size() > 0) begin
      in_valid = 1'b1;
      in_data  = stim[0].data;
      in_len   = stim[0].len;
    end else begin
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
      in_len   = LW'($urandom);
    end
  end

  // Model: each accepted frame occupies cycles [s, s+len-1] with
  // s = max(accept+2, previous frame end+1); it is pending from accept+1 to s-1.
  always @(negedge clk) begin
    slot_t         e;
    bit            ev, pending, eready, ebusy;
    logic [5:0]    expv, actv;
    int            len, s;
    logic [W-1:0]  sh;
    if (cyc >= 0) begin
      ev      = sched.exists(cyc);
      e       = ev ? sched[cyc] : '{x: 1'b0, fs: 1'b0, fl: 1'b0};
      pending = (cyc >= pend_lo) && (cyc <= pend_hi);
      ebusy   = ev || pending;
      eready  = !prev_rst && !pending;
      expv    = {eready, ebusy, ev, e.x, e.fs, e.fl};
      actv    = {in_ready, busy, x_valid, x, frame_start, frame_last};
      check($sformatf("cyc%0d {rdy,busy,xv,x,fs,fl}", cyc), 64'(actv), 64'(expv));
      if (x_valid === 1'b1) begin
        cap.push_back(x);
        if (first_xv < 0) first_xv = cyc;
        last_xv = cyc;
        if (frame_start === 1'b1) fs_cnt++;
        if (frame_last === 1'b1) fl_cnt++;
      end
      if (ev) sched.delete(cyc);
      if (rst) begin
        sched.delete();
        pend_lo  = 0;
        pend_hi  = -1;
        last_end = -10;
        prev_rst = 1'b1;
      end else begin
        prev_rst = 1'b0;
        if (in_valid && eready) begin
          len = model_len(in_len);
          s   = (cyc + 2 > last_end + 1) ? cyc + 2 : last_end + 1;
          sh  = in_data;
          for (int i = 0; i < len; i++) begin
            sched[s + i] = '{x: sh[W-1], fs: (i == 0), fl: (i == len - 1)};
            sh = sh << 1;
          end
          last_end = s + len - 1;
          pend_lo  = cyc + 1;
          pend_hi  = s - 1;
          last_acc = cyc;
          if (stim.size() > 0) void'(stim.pop_front());
        end
      end
    end
  end

  task automatic clear_cap();
    cap.delete();
    first_xv = -1;
    last_xv  = -1;
    fs_cnt   = 0;
    fl_cnt   = 0;
  endtask

  task automatic push(input logic [W-1:0] d, input logic [LW-1:0] l, input int gap);
    word_t w;
    w.data = d;
    w.len  = l;
    w.gap  = gap;
    stim.push_back(w);
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (stim.size() == 0 && cyc > last_end + 1 && cyc > pend_hi) begin
        done = 1'b1;
        break;
      end
    end
    check({name, " drained within budget"}, 64'(done), 64'(1));
  endtask

  function automatic logic [63:0] cap_bits(input int from, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = {v[62:0], cap[from + i]};
    return v;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_rel, total, r;
    logic [W-1:0] d1, d2;
    logic [LW-1:0] l;
    bit ok;

    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);

    // 1: full-width frame via in_len=0
    clear_cap();
    push(64'h3300_0000_0000_0000, 7'd0, 0);
    wait_idle("t1", 200);
    check("t1 bit count", 64'(cap.size()), 64'd64);
    check("t1 first byte", cap_bits(0, 8), 64'h33);
    check("t1 tail zeros", cap_bits(8, 56), 64'h0);
    check("t1 latency", 64'(first_xv - last_acc), 64'd2);
    check("t1 contiguous span", 64'(last_xv - first_xv + 1), 64'd64);
    check("t1 frame_start count", 64'(fs_cnt), 64'd1);
    check("t1 frame_last count", 64'(fl_cnt), 64'd1);

    // 2: back-to-back 8-bit frames stream gap-free
    clear_cap();
    push({8'hA5, 56'h0}, 7'd8, 0);
    push({8'h3C, 56'h0}, 7'd8, 0);
    wait_idle("t2", 200);
    check("t2 bits", cap_bits(0, 16), 64'hA53C);
    check("t2 span", 64'(last_xv - first_xv + 1), 64'd16);
    check("t2 frame_start count", 64'(fs_cnt), 64'd2);

    // 3: 1-bit frames show one bubble each
    clear_cap();
    push({1'b1, 63'($urandom)}, 7'd1, 0);
    push({1'b0, 63'($urandom)}, 7'd1, 0);
    push({1'b1, 63'($urandom)}, 7'd1, 0);
    push({1'b1, 63'($urandom)}, 7'd1, 0);
    wait_idle("t3", 100);
    check("t3 bits", cap_bits(0, 4), 64'hB);
    check("t3 span", 64'(last_xv - first_xv + 1), 64'd7);
    check("t3 frame_start count", 64'(fs_cnt), 64'd4);
    check("t3 frame_last count", 64'(fl_cnt), 64'd4);

    // 4: reset mid-frame with a word pending
    clear_cap();
    push({$urandom, $urandom}, 7'd0, 0);
    push({$urandom, $urandom}, 7'd12, 0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (cap.size() >= 10) begin
        ok = 1'b1;
        break;
      end
    end
    check("t4 reached bit 10", 64'(ok), 64'd1);
    rst = 1'b1;
    stim.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    n_rel = cap.size();
    repeat (100) @(posedge clk);
    #2;
    check("t4 no bits after reset", 64'(cap.size()), 64'(n_rel));
    check("t4 in_ready after reset", 64'(in_ready), 64'd1);
    check("t4 busy after reset", 64'(busy), 64'd0);

    // 5: oversize and zero length both send the full word
    clear_cap();
    d1 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    push(d1, 7'd70, 0);
    push(d2, 7'd0, 0);
    wait_idle("t5", 300);
    check("t5 bit count", 64'(cap.size()), 64'd128);
    check("t5 span", 64'(last_xv - first_xv + 1), 64'd128);
    check("t5 frame 1 data", cap_bits(0, 64), d1);
    check("t5 frame 2 data", cap_bits(64, 64), d2);

    // 6: random traffic
    clear_cap();
    total = 0;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       l = LW'($urandom_range(1, 3));
      else if (r < 8)  l = LW'($urandom_range(4, 64));
      else if (r == 8) l = 7'd0;
      else             l = LW'($urandom_range(65, 127));
      total += model_len(l);
      push({$urandom, $urandom}, l, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
    end
    wait_idle("t6", 10000);
    check("t6 total bits", 64'(cap.size()), 64'(total));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
